// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: counters advance on pix_en, all outputs registered.
// Decode is taken from the next-state counters so sync/video_on line up with x/y with zero skew.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] nx;
  logic [9:0] ny;
  logic       x_wrap;

  always_comb begin
    x_wrap = (x == X_LAST);
    nx     = x_wrap ? 10'd0 : x + 10'd1;
    ny     = y;
    if (x_wrap) begin
      ny = (y == Y_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= X_LAST;
      y           <= Y_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      x           <= nx;
      y           <= ny;
      hsync       <= (nx >= HS_START && nx <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (ny >= VS_START && ny <= VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (nx < X_VIS) && (ny < Y_VIS);
      line_start  <= (nx == 10'd0);
      frame_start <= (nx == 10'd0) && (ny == 10'd0);
    end else begin
      // Strobes are one clk wide even when pix_en is slower than clk.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default-timing instance for line/stall checks and a shrunken one for frame checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_en, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;
  logic       rst_s, pe_s, hs_s, vs_s, vo_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  // Small raster: H_TOTAL=15 (hsync x=10..12), V_TOTAL=8 (vsync y=5..6).
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pix_en(pe_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vo_s), .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, cyc, ex, hs_low, hs_first, vo_fall, ls_cnt, ls_cyc, ls_bad, seq_err;
    int frz_err, stb_err, line_len;
    int maxy, vs_low, vs_first, vo_bad, vo_cnt, fs_cnt, fs_cyc;
    logic prev_vo;

    rst = 1'b1; pix_en = 1'b0; rst_s = 1'b1; pe_s = 1'b0;

    // Reset held three cycles with pix_en toggling.
    for (int i = 0; i < 3; i++) begin
      pix_en = (i == 1);
      tick();
    end
    chk("rst_x", x, 799);
    chk("rst_y", y, 524);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0);
    chk("rst_strobes", {line_start, frame_start}, 0);

    rst = 1'b0; pix_en = 1'b1;
    tick();
    chk("first_x", x, 0);
    chk("first_y", y, 0);
    chk("first_frame_start", frame_start, 1);
    chk("first_line_start", line_start, 1);
    chk("first_video_on", video_on, 1);
    chk("first_syncs", {hsync, vsync}, 2'b11);

    // One full line with pix_en alternating 0/1.
    cyc = 0; ex = 0; hs_low = 0; hs_first = -1; vo_fall = -1;
    ls_cnt = 0; ls_cyc = -1; ls_bad = 0; seq_err = 0; prev_vo = 1'b1;
    for (int i = 0; i < 800; i++) begin
      pix_en = 1'b0; tick(); cyc++;
      if (line_start || frame_start) ls_bad++;
      if (x != 10'(ex)) seq_err++;
      pix_en = 1'b1; tick(); cyc++;
      ex = (ex + 1) % 800;
      if (x != 10'(ex)) seq_err++;
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (prev_vo && !video_on && vo_fall < 0) vo_fall = int'(x);
      prev_vo = video_on;
      if (line_start) begin ls_cnt++; ls_cyc = cyc; end
    end
    chk("line_x_sequence_errors", seq_err, 0);
    chk("line_hold_strobe_errors", ls_bad, 0);
    chk("line_hsync_low_advances", hs_low, 96);
    chk("line_hsync_first_x", hs_first, 656);
    chk("line_video_fall_x", vo_fall, 640);
    chk("line_start_count", ls_cnt, 1);
    chk("line_start_period_clk", ls_cyc, 1600);
    chk("line_wrap_y", y, 1);

    // Stall at x=655 for 50 clk.
    n = 0;
    while (x != 10'd655 && n < 2000) begin tick(); n++; end
    chk("stall_reach_x", x, 655);
    pix_en = 1'b0;
    frz_err = 0; stb_err = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (x != 10'd655 || y != 10'd1 || hsync !== 1'b1 || vsync !== 1'b1 || video_on !== 1'b0)
        frz_err++;
      if (line_start || frame_start) stb_err++;
    end
    chk("stall_frozen_errors", frz_err, 0);
    chk("stall_strobe_errors", stb_err, 0);
    pix_en = 1'b1;
    tick();
    chk("stall_resume_x", x, 656);
    chk("stall_resume_hsync", hsync, 0);

    // pix_en tied high: one full line, decode points in clk.
    n = 0;
    while (!line_start && n < 2000) begin tick(); n++; end
    chk("tied_line_start", line_start, 1);
    chk("tied_line_y", y, 2);
    hs_low = 0; hs_first = -1; vo_fall = -1; line_len = -1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (!video_on && vo_fall < 0) vo_fall = int'(x);
      if (line_start && line_len < 0) line_len = i;
    end
    chk("tied_line_len_clk", line_len, 800);
    chk("tied_hsync_first_x", hs_first, 656);
    chk("tied_hsync_low_clk", hs_low, 96);
    chk("tied_video_fall_x", vo_fall, 640);

    // Small raster: full frame with pix_en alternating.
    pe_s = 1'b1;
    tick();
    chk("s_rst_x", x_s, 14);
    chk("s_rst_y", y_s, 7);
    rst_s = 1'b0;
    tick();
    chk("s_first_xy", {x_s, y_s}, 20'd0);
    chk("s_first_frame_start", fs_s, 1);
    cyc = 0; maxy = 0; vs_low = 0; vs_first = -1; vo_bad = 0; vo_cnt = 0;
    fs_cnt = 0; fs_cyc = -1; ls_cnt = 0; ls_bad = 0;
    for (int i = 0; i < 120; i++) begin
      pe_s = 1'b0; tick(); cyc++;
      if (ls_s || fs_s) ls_bad++;
      pe_s = 1'b1; tick(); cyc++;
      if (int'(y_s) > maxy) maxy = int'(y_s);
      if (!vs_s) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(y_s);
      end
      if (vo_s) vo_cnt++;
      if (vo_s && y_s >= 10'd4) vo_bad++;
      if (ls_s) ls_cnt++;
      if (fs_s) begin fs_cnt++; fs_cyc = cyc; end
    end
    chk("s_frame_max_y", maxy, 7);
    chk("s_vsync_low_advances", vs_low, 30);
    chk("s_vsync_first_y", vs_first, 5);
    chk("s_video_outside_rows", vo_bad, 0);
    chk("s_video_on_advances", vo_cnt, 32);
    chk("s_frame_start_count", fs_cnt, 1);
    chk("s_frame_period_clk", fs_cyc, 240);
    chk("s_line_start_count", ls_cnt, 8);
    chk("s_hold_strobe_errors", ls_bad, 0);

    // Mid-frame reset at (5,3).
    n = 0;
    while (!(x_s == 10'd5 && y_s == 10'd3) && n < 500) begin tick(); n++; end
    chk("s_mid_reach", {x_s, y_s}, {10'd5, 10'd3});
    rst_s = 1'b1;
    tick();
    chk("s_mid_rst_xy", {x_s, y_s}, {10'd14, 10'd7});
    chk("s_mid_rst_flags", {hs_s, vs_s, vo_s, ls_s, fs_s}, 5'b11000);
    rst_s = 1'b0;
    tick();
    chk("s_mid_resume_xy", {x_s, y_s}, 20'd0);
    chk("s_mid_resume_strobes", {ls_s, fs_s}, 2'b11);
    chk("s_mid_resume_syncs", {hs_s, vs_s}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
